// File: rtl/jtbubl_tile_draw_if.sv
// Request, ROM and line-buffer signals of the tile-row drawer.
// The slave side is the drawer; the master side is the object scanner and memory.
interface jtbubl_tile_draw_if #(
   parameter int CW   = 14,
   parameter int PALW = 4,
   parameter int BPP  = 4,
   parameter int TW   = 8,
   parameter int ROWW = 3
);
   logic                 LHBL;
   logic                 req;
   logic [CW-1:0]        req_code;
   logic [PALW-1:0]      req_pal;
   logic                 req_hflip;
   logic                 req_vflip;
   logic [ROWW-1:0]      req_row;
   logic [8:0]           req_xpos;
   logic                 full;
   logic                 busy;
   logic [CW+ROWW-1:0]   rom_addr;
   logic [BPP*TW-1:0]    rom_data;
   logic                 rom_ok;
   logic                 rom_cs;
   logic [8:0]           buf_addr;
   logic [PALW+BPP-1:0]  buf_din;
   logic                 buf_we;

   modport master (
      output LHBL, req, req_code, req_pal, req_hflip, req_vflip, req_row, req_xpos,
      output rom_data, rom_ok,
      input  full, busy, rom_addr, rom_cs, buf_addr, buf_din, buf_we
   );

   modport slave (
      input  LHBL, req, req_code, req_pal, req_hflip, req_vflip, req_row, req_xpos,
      input  rom_data, rom_ok,
      output full, busy, rom_addr, rom_cs, buf_addr, buf_din, buf_we
   );
endinterface

// File: rtl/jtbubl_tile_draw.sv
// Object tile-row drawer: queued requests, one ROM word per request, TW pixels
// written to the line buffer with transparency and per-tile flips.
module jtbubl_tile_draw #(
   parameter int CW    = 14,
   parameter int PALW  = 4,
   parameter int BPP   = 4,
   parameter int TW    = 8,
   parameter int ROWW  = 3,
   parameter int QAW   = 1,
   parameter int ALPHA = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   jtbubl_tile_draw_if.slave bus
);
   localparam int              PIXW      = $clog2(TW);
   localparam int              DEPTH     = 2**QAW;
   localparam logic [BPP-1:0]  ALPHA_PEN = BPP'(ALPHA);

   typedef struct packed {
      logic [CW-1:0]   code;
      logic [PALW-1:0] pal;
      logic            hflip;
      logic            vflip;
      logic [ROWW-1:0] row;
      logic [8:0]      xpos;
   } entry_t;

   typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;

   state_t            state_q, state_d;
   entry_t            fifo_q [DEPTH];
   logic [QAW-1:0]    wr_q, rd_q, rd_nxt;
   logic [QAW:0]      cnt_q;
   entry_t            cur_q, req_entry, load_entry;
   logic [BPP*TW-1:0] data_q;
   logic [PIXW-1:0]   pix_q, bit_idx;
   logic              first_q;
   logic              push, pop, load, last_pix, capture, full;
   logic [BPP-1:0]    pen;

   assign req_entry = '{code: bus.req_code, pal: bus.req_pal, hflip: bus.req_hflip,
                        vflip: bus.req_vflip, row: bus.req_row, xpos: bus.req_xpos};
   assign full     = (cnt_q == (QAW+1)'(DEPTH));
   assign push     = bus.req && !full && bus.LHBL;
   assign last_pix = (pix_q == PIXW'(TW-1));
   assign pop      = (state_q == DRAW) && last_pix && bus.LHBL;
   assign rd_nxt   = rd_q + QAW'(1);
   assign capture  = (state_q == FETCH) && (state_d == DRAW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // When the last queued entry is popped while a new one arrives, the new head
   // is taken straight from the request bus so back-to-back drawing never stalls.
   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      load_entry = fifo_q[rd_q];
      case (state_q)
         IDLE:
            if (cnt_q != '0) begin
               state_d = FETCH;
               load    = 1'b1;
            end
         FETCH:
            if (!first_q && bus.rom_ok) state_d = DRAW;
         DRAW:
            if (last_pix) begin
               if (cnt_q > (QAW+1)'(1) || push) begin
                  state_d    = FETCH;
                  load       = 1'b1;
                  load_entry = (cnt_q == (QAW+1)'(1)) ? req_entry : fifo_q[rd_nxt];
               end else begin
                  state_d = IDLE;
               end
            end
         default: state_d = IDLE;
      endcase
      if (!bus.LHBL) begin
         state_d = IDLE;
         load    = 1'b0;
      end
   end

   always_comb begin
      bit_idx = cur_q.hflip ? pix_q : PIXW'(TW-1) - pix_q;
      pen     = '0;
      for (int k = 0; k < BPP; k++) pen[k] = data_q[k*TW + int'(bit_idx)];

      bus.full     = full;
      bus.busy     = (state_q != IDLE) || (cnt_q != '0);
      bus.rom_cs   = (state_q == FETCH);
      bus.rom_addr = {cur_q.code, cur_q.row ^ {ROWW{cur_q.vflip}}};
      bus.buf_addr = '0;
      bus.buf_din  = '0;
      bus.buf_we   = 1'b0;
      if (state_q == DRAW) begin
         bus.buf_addr = cur_q.xpos + 9'(pix_q);
         bus.buf_din  = {cur_q.pal, pen};
         bus.buf_we   = (pen != ALPHA_PEN);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_q] <= req_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (!bus.LHBL) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + QAW'(1);
         if (pop)  rd_q <= rd_nxt;
         cnt_q <= cnt_q + (QAW+1)'(push) - (QAW+1)'(pop);
      end
   end

   // first_q masks rom_ok during the first FETCH cycle of every fetch, since ok
   // may still be asserted for the previous address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q   <= '0;
         data_q  <= '0;
         pix_q   <= '0;
         first_q <= 1'b0;
      end else begin
         if (load)                    cur_q   <= load_entry;
         if (load)                    first_q <= 1'b1;
         else if (state_q == FETCH)   first_q <= 1'b0;
         if (capture) begin
            data_q <= bus.rom_data;
            pix_q  <= '0;
         end else if (state_q == DRAW) begin
            pix_q  <= pix_q + PIXW'(1);
         end
      end
   end
endmodule

// File: tb/tb_jtbubl_tile_draw.sv
// Directed and randomized bench for jtbubl_tile_draw with a ROM responder and
// a line-buffer write monitor compared against a pixel-list reference model.
module tb_jtbubl_tile_draw;
   localparam int CW = 14, PALW = 4, BPP = 4, TW = 8, ROWW = 3;

   logic clk, rst_n;
   int   n_cmp = 0, n_fail = 0;
   int   cyc = 0, last_we_cyc = 0, first_we_cyc = 0, cs_rise_cyc = 0, idle_cyc = 0;
   int   ok_delay = 1, cs_cnt = 0;
   bit   ok_hold = 0, cs_prev = 0;
   logic [31:0] rom_tab [int];
   logic [16:0] wq [$];
   logic [16:0] exp_q [$];

   jtbubl_tile_draw_if #(.CW(CW), .PALW(PALW), .BPP(BPP), .TW(TW), .ROWW(ROWW)) bus ();

   jtbubl_tile_draw #(.CW(CW), .PALW(PALW), .BPP(BPP), .TW(TW), .ROWW(ROWW),
                      .QAW(1), .ALPHA(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rom_lookup(input logic [16:0] a);
      if (rom_tab.exists(int'(a))) return rom_tab[int'(a)];
      return 32'(a) * 32'h9E3779B1;
   endfunction

   // ROM: ok pulses ok_delay cycles after cs rises, or stays high in hold mode.
   initial begin
      bus.rom_ok = 0;
      bus.rom_data = '0;
      forever begin
         @(negedge clk);
         if (ok_hold) begin
            bus.rom_ok = 1;
            bus.rom_data = rom_lookup(bus.rom_addr);
         end else if (bus.rom_cs === 1'b1) begin
            bus.rom_ok = (cs_cnt == ok_delay);
            bus.rom_data = rom_lookup(bus.rom_addr);
            cs_cnt++;
         end else begin
            cs_cnt = 0;
            bus.rom_ok = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.rom_cs === 1'b1 && !cs_prev) cs_rise_cyc = cyc;
         cs_prev = (bus.rom_cs === 1'b1);
         if (bus.buf_we === 1'b1) begin
            if (wq.size() == 0) first_we_cyc = cyc;
            wq.push_back({bus.buf_addr, bus.buf_din});
            last_we_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] exp_rom_addr(input logic [CW-1:0] code,
                                                input logic [ROWW-1:0] row, input logic vf);
      logic [ROWW-1:0] r;
      r = vf ? ROWW'((2**ROWW) - 1 - int'(row)) : row;
      return {code, r};
   endfunction

   // Reference: list of (address, {pal,pen}) writes a tile row should produce.
   task automatic build_exp(input logic [31:0] data, input logic [PALW-1:0] pal,
                            input logic hf, input logic [8:0] xpos);
      for (int i = 0; i < TW; i++) begin
         int col;
         logic [BPP-1:0] p;
         col = hf ? i : TW - 1 - i;
         for (int k = 0; k < BPP; k++) p[k] = data[k*TW + col];
         if (p != 0) exp_q.push_back({9'((int'(xpos) + i) % 512), pal, p});
      end
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_nwr"}, wq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
         check($sformatf("%s_wr%0d", tag, i), wq[i], exp_q[i]);
   endtask

   task automatic set_req(input logic [CW-1:0] code, input logic [PALW-1:0] pal,
                          input logic hf, input logic vf, input logic [ROWW-1:0] row,
                          input logic [8:0] xpos);
      bus.req_code = code; bus.req_pal = pal; bus.req_hflip = hf;
      bus.req_vflip = vf; bus.req_row = row; bus.req_xpos = xpos;
      bus.req = 1;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300 && bus.busy === 1'b1; i++) step();
      idle_cyc = cyc;
      check({tag, "_idle"}, bus.busy, 0);
   endtask

   task automatic run_tile(input string tag, input logic [CW-1:0] code,
                           input logic [PALW-1:0] pal, input logic hf, input logic vf,
                           input logic [ROWW-1:0] row, input logic [8:0] xpos,
                           input logic [31:0] data, input int dly);
      logic [16:0] a;
      ok_delay = dly;
      a = exp_rom_addr(code, row, vf);
      rom_tab[int'(a)] = data;
      wq.delete();
      exp_q.delete();
      build_exp(data, pal, hf, xpos);
      set_req(code, pal, hf, vf, row, xpos);
      step();
      bus.req = 0;
      check({tag, "_cs_early"}, bus.rom_cs, 0);
      step();
      check({tag, "_cs"}, bus.rom_cs, 1);
      check({tag, "_addr"}, bus.rom_addr, a);
      wait_idle(tag);
      compare_writes(tag);
      if (exp_q.size() > 0) check({tag, "_busydrop"}, idle_cyc - last_we_cyc, 1);
   endtask

   initial begin
      logic [CW-1:0] ca, cb;
      logic [PALW-1:0] pa, pb;
      logic [31:0] da, db;
      rst_n = 0;
      bus.LHBL = 1;
      bus.req = 0;
      set_req('0, '0, 0, 0, '0, '0);
      bus.req = 0;
      step(); step();
      check("rst_full", bus.full, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_cs", bus.rom_cs, 0);
      check("rst_we", bus.buf_we, 0);
      check("rst_romaddr", bus.rom_addr, 0);
      check("rst_bufaddr", bus.buf_addr, 0);
      check("rst_din", bus.buf_din, 0);
      rst_n = 1;
      step();
      check("rst_rel_busy", bus.busy, 0);

      run_tile("single", 14'h123, 4'd3, 0, 0, 3'd5, 9'h010, 32'hFFFF_FFFF, 3);
      check("single_romaddr", bus.rom_addr, 17'h091D);
      check("single_first", wq[0], {9'h010, 8'h3F});
      check("single_last", wq[7], {9'h017, 8'h3F});

      run_tile("vhflip", 14'h0A5, 4'd7, 1, 1, 3'd5, 9'h040, 32'h0000_0080, 2);
      check("vhflip_row", bus.rom_addr[2:0], 3'd2);
      check("vhflip_n", wq.size(), 1);
      check("vhflip_x", wq[0][16:8], 9'h047);

      run_tile("transp", 14'h0B6, 4'd1, 0, 0, 3'd0, 9'h100, 32'h0000_000F, 1);
      check("transp_n", wq.size(), 4);
      check("transp_lo", wq[0][16:8], 9'h104);
      check("transp_hi", wq[3][16:8], 9'h107);

      run_tile("wrap", 14'h0C7, 4'd9, 0, 0, 3'd1, 9'h1FC, 32'hFFFF_FFFF, 2);
      check("wrap_top", wq[3][16:8], 9'h1FF);
      check("wrap_zero", wq[4][16:8], 9'h000);

      // rom_ok held high: capture still waits for the second FETCH cycle
      ok_hold = 1;
      run_tile("hold", 14'h0D8, 4'd5, 0, 0, 3'd3, 9'h0A0, $urandom | 32'h8080_8080, 1);
      check("hold_lat", first_we_cyc - cs_rise_cyc, 2);
      ok_hold = 0;
      step();

      for (int n = 0; n < 8; n++)
         run_tile($sformatf("rnd%0d", n), 14'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), 3'($urandom), 9'($urandom_range(0, 511)), $urandom,
                  $urandom_range(1, 4));

      // queue: third push while full is dropped, two tiles drawn in order
      ca = 14'h1111; cb = 14'h2222; pa = 4'd2; pb = 4'd6;
      da = $urandom; db = $urandom;
      rom_tab[int'(exp_rom_addr(ca, 3'd1, 0))] = da;
      rom_tab[int'(exp_rom_addr(cb, 3'd4, 1))] = db;
      wq.delete(); exp_q.delete();
      build_exp(da, pa, 0, 9'h020);
      build_exp(db, pb, 1, 9'h080);
      ok_delay = 4;
      set_req(ca, pa, 0, 0, 3'd1, 9'h020);
      step();
      check("q_full0", bus.full, 0);
      set_req(cb, pb, 1, 1, 3'd4, 9'h080);
      step();
      check("q_full1", bus.full, 1);
      set_req(14'h3333, 4'd8, 0, 0, 3'd0, 9'h0F0);
      step();
      bus.req = 0;
      check("q_full2", bus.full, 1);
      check("q_addrA", bus.rom_addr, exp_rom_addr(ca, 3'd1, 0));
      wait_idle("queue");
      compare_writes("queue");
      check("q_full_end", bus.full, 0);

      // flush mid-draw after three pixels with one entry still queued
      wq.delete(); exp_q.delete();
      ok_delay = 1;
      rom_tab[int'(exp_rom_addr(14'h0444, 3'd2, 0))] = 32'hFFFF_FFFF;
      build_exp(32'hFFFF_FFFF, 4'd4, 0, 9'h060);
      set_req(14'h0444, 4'd4, 0, 0, 3'd2, 9'h060);
      step();
      set_req(14'h0555, 4'd5, 0, 0, 3'd3, 9'h0C0);
      step();
      bus.req = 0;
      for (int i = 0; i < 100 && wq.size() < 3; i++) step();
      check("fl_n3", wq.size(), 3);
      bus.LHBL = 0;
      step();
      check("fl_we", bus.buf_we, 0);
      check("fl_cs", bus.rom_cs, 0);
      check("fl_busy", bus.busy, 0);
      check("fl_full", bus.full, 0);
      set_req(14'h0666, 4'd6, 0, 0, 3'd0, 9'h000);
      step();
      bus.req = 0;
      bus.LHBL = 1;
      for (int i = 0; i < 40; i++) step();
      check("fl_nowr", wq.size(), 3);
      check("fl_busy_end", bus.busy, 0);
      for (int i = 0; i < 3; i++) check($sformatf("fl_wr%0d", i), wq[i], exp_q[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/jtbubl_tile_draw.md
Name: jtbubl_tile_draw

Overview:
Parametrised object/tile row renderer for the object line-buffer path. It accepts tile-row draw requests through a small request FIFO and fetches one ROM word per request over the SDRAM cs/ok handshake. It then writes TW pixels per request into a line buffer, skipping transparent pens and honouring per-tile hflip/vflip. Compared with the fixed 8-pixel, two-tile drawer, it adds configurable bit depth, tile width and queue depth, transparency gating, and decoupling between tile collection and drawing.

Parameters:
CW, 14, tile code width (bank bits included by caller)
PALW, 4, palette field width
BPP, 4, bits per pixel (planes)
TW, 8, tile width in pixels; rom_data width = BPP*TW
ROWW, 3, row-select width; tile height = 2**ROWW
QAW, 1, FIFO address width; depth = 2**QAW
ALPHA, 0, transparent pen value (BPP bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
LHBL  in  1  horizontal blank, active low; low = flush
req  in  1  push a draw request (ignored when full=1)
req_code  in  CW  tile code
req_pal  in  PALW  palette
req_hflip  in  1  horizontal flip
req_vflip  in  1  vertical flip
req_row  in  ROWW  row within tile
req_xpos  in  9  line-buffer x of leftmost drawn pixel
full  out  1  FIFO full
busy  out  1  FIFO non-empty or draw in progress
rom_addr  out  CW+ROWW  {code, row^{ROWW{vflip}}}
rom_data  in  BPP*TW  planar tile row
rom_ok  in  1  rom_data valid for current rom_addr
rom_cs  out  1  ROM request
buf_addr  out  9  line-buffer write address
buf_din  out  PALW+BPP  {pal, pen}
buf_we  out  1  line-buffer write strobe

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, state IDLE; full=0, busy=0, rom_cs=0, buf_we=0, rom_addr=0, buf_addr=0, buf_din=0.
- FIFO: push on req && !full && LHBL. Pop when DRAW completes. Push and pop in the same cycle are both honoured; occupancy is unchanged. full = occupancy==2**QAW.
- States: IDLE -> FETCH -> DRAW -> (FETCH if FIFO non-empty after pop, else IDLE).
- IDLE: when the FIFO is non-empty, latch the head entry, drive rom_addr, set rom_cs=1, go to FETCH next cycle. Minimum latency from req edge (empty FIFO) to rom_cs=1 is 2 cycles.
- FETCH: rom_ok is ignored during the first FETCH cycle, which guards a stale ok from the previous address. On rom_ok in a later cycle: capture rom_data, rom_cs=0, go to DRAW. rom_cs stays high and rom_addr stays stable until capture.
- Pixel decode: plane k occupies rom_data[k*TW +: TW]. Bit TW-1 is the leftmost pixel when hflip=0. When hflip=1, bit 0 is the leftmost pixel. pen[k] = plane k bit.
- DRAW: exactly TW cycles, pixel i=0..TW-1 in order. buf_addr = (xpos+i) mod 512 (9-bit wrap). buf_din = {pal, pen}. buf_we=1 only when pen != ALPHA, else 0 with buf_addr still advancing. buf_we=0 outside DRAW.
- Back-to-back: the last DRAW cycle pops the FIFO. If an entry remains, the next cycle is FETCH with the new rom_addr and rom_cs=1.
- LHBL low (any state): FIFO flushed, state IDLE, rom_cs=0, buf_we=0 on the next edge. Pushes are ignored while LHBL=0. A partially drawn tile is abandoned, with no resume.
- rom_ok held high continuously: capture is still gated by the first-FETCH-cycle ignore rule.
- busy = (state!=IDLE) || FIFO non-empty.

Test Plan:
- Single request: code=0x123, row=5, vflip=0, xpos=0x010, pal=3, rom_data=0xFFFFFFFF, rom_ok 3 cycles after rom_cs -> rom_addr={0x123,3'd5}; 8 writes at 0x010..0x017, buf_din=0x3F; busy drops after the last write.
- vflip/hflip: row=5, vflip=1 -> rom_addr row field=2. rom_data with plane0=0x80 only, hflip=1 -> the single pen-1 write lands at xpos+7.
- Transparency: rom_data=0x0000000F (only pixels 4..7 plane0 set), ALPHA=0 -> buf_we asserted only for addresses xpos+4..xpos+7.
- Wrap: xpos=0x1FC -> writes to 0x1FC..0x1FF then 0x000..0x003.
- Queue: 3 pushes back-to-back with QAW=1 and rom_ok delayed -> full=1 after two queued entries, third push dropped; two tiles drawn in push order.
- Flush: LHBL falls mid-DRAW after 3 pixels with one entry queued -> buf_we=0 and rom_cs=0 next cycle, busy=0, no further writes after LHBL returns high.
